warp_fb_writer: RTL and testbench
=================================

# warp_fb_writer

Downstream stage of the perspective pixel mapper: takes each mapped destination coordinate (signed divider quotients) with its source pixel, discards coordinates outside the 640x480 screen, converts in-range ones to a linear frame-buffer address, and queues writes to the frame-buffer memory port through a small FIFO. It absorbs the mismatch between the mapper's output rate and a shared memory port that can stall.

## Interface
- PIXEL_W, 12: pixel width (4:4:4 RGB).
- FIFO_DEPTH, 8: write-queue entries, power of two, at least 4.
- H_ACTIVE, 640: screen width in pixels.
- V_ACTIVE, 480: screen height in lines.

- clk  in  1  system clock; all logic is single-clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  a mapped sample is presented.
- in_ready  out  1  the sample is accepted on a clk edge with in_valid & in_ready.
- ox_signed  in  37  signed destination x (divider quotient).
- oy_signed  in  37  signed destination y.
- pixel  in  PIXEL_W  source pixel value.
- frame_start  in  1  one-cycle pulse; clears clip_count.
- wr_en  out  1  write request; equals FIFO not empty.
- wr_addr  out  19  linear address oy*H_ACTIVE+ox.
- wr_data  out  PIXEL_W  pixel to write.
- wr_ack  in  1  memory accepts the head entry when wr_en & wr_ack.
- clip_count  out  16  samples discarded since the last frame_start; saturates at 0xFFFF.
- busy  out  1  stage 1 valid or FIFO not empty.

## Operation
- Stage 1 registers each accepted sample: s1_valid, s1_in_range, s1_addr, s1_pixel.
- In range means 0 <= ox_signed < H_ACTIVE and 0 <= oy_signed < V_ACTIVE, compared at the full 37-bit signed width. Never truncate before comparing: for example, x = 1024+5 is out of range.
- Address = (oy<<9) + (oy<<7) + ox, using the low 10/9 bits once in range. Maximum address is 307199.
- Stage 2: if s1_valid & s1_in_range, push {s1_addr, s1_pixel} into the FIFO.
- If s1_valid & !s1_in_range, there is no push and clip_count increments, saturating at 0xFFFF.
- in_ready = (fifo_count + s1_valid) < FIFO_DEPTH. It is computed from registers only, with no combinational path from in_valid or wr_ack.
- The FIFO head drives wr_addr and wr_data. Both are held stable while wr_en & !wr_ack.
- On wr_en & wr_ack, pop the head. The next entry, if any, is presented on the following cycle.
- Push and pop in the same cycle: fifo_count is unchanged and ordering is preserved. Writes leave in acceptance order.
- frame_start does not flush the FIFO or stage 1.
- On frame_start, clip_count loads 0. If a clip event happens in the same cycle, it loads 1 instead.

## Timing
- Reset values: in_ready=1, wr_en=0, wr_addr=0, wr_data=0, clip_count=0, busy=0. FIFO pointers, count and s1_valid are all 0.
- Latency with an empty FIFO: a sample accepted at edge N gives wr_en=1 after edge N+2, with matching address and data.
- Clip latency: clip_count updates after edge N+1 for a sample accepted at edge N.
- Throughput is one sample per cycle while wr_ack is held high.
- Full queue: with wr_ack=0, at most FIFO_DEPTH in-range samples are accepted. in_ready then falls and no entry is lost or overwritten.
- Reset asserted mid-operation discards stage 1 and all FIFO contents on that edge. Outputs take their reset values the following cycle.

## Structure
- Shared package holds H_ACTIVE, V_ACTIVE, ADDR_W=19, PIXEL_W and the max address constant. The mapper and the display reader use the same package.
- One sub-module: sync_fifo, parameterised by width (ADDR_W+PIXEL_W) and depth. It has push, pop, head, count, empty and full.
- The top level contains only stage 1, the clip counter and the ready logic.

## Test plan
- Sample (ox=0, oy=0, pixel=0xABC) with wr_ack=1 -> one write addr=0, data=0xABC, 2 cycles after acceptance. clip_count stays 0.
- Samples (639,479), (-1,10), (640,0), (5,480), (1029,3) -> one write to addr 307199. clip_count=4.
- wr_ack=0 with 10 back-to-back in-range samples -> exactly 8 accepted and in_ready=0. Releasing wr_ack drains 8 writes in order, then the remaining 2 are accepted.
- wr_ack toggling every cycle with a continuous input stream -> no reordering, drops or duplicates. Addresses and data stay stable while wr_ack=0.
- 70000 clipped samples -> clip_count saturates at 0xFFFF. frame_start together with a clipped sample -> clip_count=1.
- Reset asserted with 5 queued entries -> next cycle wr_en=0, busy=0, in_ready=1. No stale write appears afterwards.

Source files
------------

// File: rtl/warp_fb_writer_pkg.sv
// Shared frame-buffer geometry and address helper for the warp pipeline.
// Used by the mapper, this writer and the display reader.
package warp_fb_writer_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int ADDR_W   = 19;
    localparam int PIXEL_W  = 12;
    localparam int COORD_W  = 37;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    // y*640 + x as two shifts and adds; only valid for in-range coordinates
    function automatic logic [ADDR_W-1:0] fb_addr(
        input logic [Y_W-1:0] y,
        input logic [X_W-1:0] x
    );
        return (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/warp_fb_writer_sync_fifo.sv
// Write queue with a registered head entry: a push becomes visible at the
// head one cycle after it lands in storage; pops refill the head directly.
module warp_fb_writer_sync_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic             head_vld_q, head_vld_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_pop;
    logic             load;

    always_comb begin
        do_pop     = pop & head_vld_q;
        load       = (mem_cnt_q != '0) & (~head_vld_q | do_pop);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
        mem_cnt_d  = mem_cnt_q + CNT_W'(push) - CNT_W'(load);
        head_vld_d = load | (head_vld_q & ~do_pop);
        head_d     = load ? mem_q[rd_ptr_q] : head_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = head_q;
    assign count = mem_cnt_q + CNT_W'(head_vld_q);
    assign empty = ~head_vld_q;
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/warp_fb_writer.sv
// Clips mapped coordinates to the screen and queues linear frame-buffer
// writes toward a memory port that may stall.
module warp_fb_writer #(
    parameter int PIXEL_W    = warp_fb_writer_pkg::PIXEL_W,
    parameter int FIFO_DEPTH = 8,
    parameter int H_ACTIVE   = warp_fb_writer_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = warp_fb_writer_pkg::V_ACTIVE
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic signed [warp_fb_writer_pkg::COORD_W-1:0] ox_signed,
    input  logic signed [warp_fb_writer_pkg::COORD_W-1:0] oy_signed,
    input  logic [PIXEL_W-1:0]                        pixel,
    input  logic                                      frame_start,
    output logic                                      wr_en,
    output logic [warp_fb_writer_pkg::ADDR_W-1:0]     wr_addr,
    output logic [PIXEL_W-1:0]                        wr_data,
    input  logic                                      wr_ack,
    output logic [15:0]                               clip_count,
    output logic                                      busy
);

    import warp_fb_writer_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = ADDR_W + PIXEL_W;

    logic               s1_valid_q, s1_valid_d;
    logic               s1_in_range_q, s1_in_range_d;
    logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;
    logic [PIXEL_W-1:0] s1_pixel_q, s1_pixel_d;
    logic [15:0]        clip_q, clip_d;

    logic               accept;
    logic               x_ok;
    logic               y_ok;
    logic               push;
    logic               clip_evt;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ENT_W-1:0]   head;

    always_comb begin
        accept = in_valid & in_ready;
        // full-width compare so large quotients never alias onto the screen
        x_ok = ~ox_signed[COORD_W-1]
             & ($unsigned(ox_signed) < COORD_W'(H_ACTIVE));
        y_ok = ~oy_signed[COORD_W-1]
             & ($unsigned(oy_signed) < COORD_W'(V_ACTIVE));

        s1_valid_d    = accept;
        s1_in_range_d = s1_in_range_q;
        s1_addr_d     = s1_addr_q;
        s1_pixel_d    = s1_pixel_q;
        if (accept) begin
            s1_in_range_d = x_ok & y_ok;
            s1_addr_d     = fb_addr(oy_signed[Y_W-1:0], ox_signed[X_W-1:0]);
            s1_pixel_d    = pixel;
        end

        push     = s1_valid_q & s1_in_range_q;
        clip_evt = s1_valid_q & ~s1_in_range_q;

        clip_d = clip_q;
        if (frame_start) begin
            clip_d = 16'(clip_evt);
        end else if (clip_evt && clip_q != 16'hFFFF) begin
            clip_d = clip_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_in_range_q <= 1'b0;
            s1_addr_q     <= '0;
            s1_pixel_q    <= '0;
            clip_q        <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_in_range_q <= s1_in_range_d;
            s1_addr_q     <= s1_addr_d;
            s1_pixel_q    <= s1_pixel_d;
            clip_q        <= clip_d;
        end
    end

    warp_fb_writer_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({s1_addr_q, s1_pixel_q}),
        .pop       (wr_ack),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // reserve a slot for the sample already sitting in stage 1
    assign in_ready = ~fifo_full
                    & ~(s1_valid_q & (fifo_count == CNT_W'(FIFO_DEPTH - 1)));
    assign wr_en      = ~fifo_empty;
    assign wr_addr    = head[ENT_W-1:PIXEL_W];
    assign wr_data    = head[PIXEL_W-1:0];
    assign clip_count = clip_q;
    assign busy       = s1_valid_q | (fifo_count != '0);

endmodule

// File: tb/tb_warp_fb_writer.sv
// Randomised and directed checks of warp_fb_writer against a queue-based
// model of accepted samples and a clip counter model.
module tb_warp_fb_writer;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [36:0] ox_signed;
    logic signed [36:0] oy_signed;
    logic [11:0]        pixel;
    logic               frame_start;
    logic               wr_en;
    logic [18:0]        wr_addr;
    logic [11:0]        wr_data;
    logic               wr_ack;
    logic [15:0]        clip_count;
    logic               busy;

    typedef struct packed {
        logic [18:0] addr;
        logic [11:0] data;
    } wr_t;

    wr_t    exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     clip_m = 0;
    bit     pend_clip = 0;
    int     n_writes = 0;
    int     last_addr = 0;
    bit     tog_en = 0;
    longint mx, my;
    bit     m_inr;
    wr_t    m_ent;

    always #5 clk = ~clk;

    warp_fb_writer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ox_signed   (ox_signed),
        .oy_signed   (oy_signed),
        .pixel       (pixel),
        .frame_start (frame_start),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .clip_count  (clip_count),
        .busy        (busy)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model: sees each cycle's handshake just before its edge
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            clip_m    = 0;
            pend_clip = 0;
        end else begin
            chk("clip_count", clip_count, clip_m);
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", wr_en, 0);
            end else if (wr_en) begin
                chk("wr_addr", wr_addr, exp_q[0].addr);
                chk("wr_data", wr_data, exp_q[0].data);
                if (wr_ack) begin
                    last_addr = exp_q[0].addr;
                    void'(exp_q.pop_front());
                    n_writes++;
                end
            end
            if (frame_start) clip_m = pend_clip ? 1 : 0;
            else if (pend_clip && clip_m < 65535) clip_m++;
            pend_clip = 0;
            if (in_valid && in_ready) begin
                mx = ox_signed;
                my = oy_signed;
                m_inr = (mx >= 0) && (mx < 640) && (my >= 0) && (my < 480);
                if (m_inr) begin
                    m_ent.addr = 19'(my * 640 + mx);
                    m_ent.data = pixel;
                    exp_q.push_back(m_ent);
                end else begin
                    pend_clip = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (tog_en) wr_ack = ~wr_ack;
    endtask

    task automatic send(input longint x, input longint y, input int p);
        int t = 0;
        bit rdy;
        in_valid  = 1'b1;
        ox_signed = 37'(x);
        oy_signed = 37'(y);
        pixel     = 12'(p);
        do begin
            rdy = in_ready;
            step();
            t++;
        end while (!rdy && t < 2000);
        if (!rdy) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int t = 0;
        in_valid = 1'b0;
        while (busy && t < 500) begin
            step();
            t++;
        end
        if (busy) chk("drain_timeout", 1, 0);
        step();
        step();
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        int w0;
        int i;
        bit rdy;
        longint x, y;
        reset = 1'b1;
        in_valid = 1'b0;
        frame_start = 1'b0;
        wr_ack = 1'b1;
        ox_signed = '0;
        oy_signed = '0;
        pixel = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_clip", clip_count, 0);
        chk("rst_busy", busy, 0);

        // latency of a single sample into an empty queue
        in_valid = 1'b1;
        ox_signed = '0;
        oy_signed = '0;
        pixel = 12'hABC;
        step();
        in_valid = 1'b0;
        chk("lat_n0_wr_en", wr_en, 0);
        step();
        chk("lat_n1_wr_en", wr_en, 0);
        step();
        chk("lat_n2_wr_en", wr_en, 1);
        chk("lat_n2_addr", wr_addr, 0);
        chk("lat_n2_data", wr_data, 12'hABC);
        drain();
        chk("lat_clip", clip_count, 0);

        // screen-edge coordinates
        pulse_fs();
        w0 = n_writes;
        send(639, 479, 12'h123);
        send(-1, 10, 12'h001);
        send(640, 0, 12'h002);
        send(5, 480, 12'h003);
        send(1029, 3, 12'h004);
        drain();
        chk("bnd_writes", n_writes - w0, 1);
        chk("bnd_addr", last_addr, 307199);
        chk("bnd_clip", clip_count, 4);

        // full queue under a stalled port
        wr_ack = 1'b0;
        w0 = n_writes;
        i = 0;
        in_valid = 1'b1;
        ox_signed = 37'(0);
        oy_signed = 37'(0);
        pixel = 12'h100;
        repeat (20) begin
            rdy = in_ready;
            step();
            if (rdy && i < 10) begin
                i++;
                ox_signed = 37'(i * 7);
                oy_signed = 37'(i);
                pixel = 12'(12'h100 + i);
            end
        end
        chk("full_accepted", i, 8);
        chk("full_in_ready", in_ready, 0);
        chk("full_no_writes", n_writes - w0, 0);
        wr_ack = 1'b1;
        for (int k = 8; k < 10; k++) send(k * 7, k, 12'h100 + k);
        drain();
        chk("full_writes", n_writes - w0, 10);

        // continuous random stream with wr_ack toggling every cycle
        pulse_fs();
        tog_en = 1'b1;
        repeat (300) begin
            x = longint'($urandom_range(0, 750)) - 50;
            y = longint'($urandom_range(0, 560)) - 40;
            if ($urandom_range(0, 15) == 0) x = 1024 + $urandom_range(0, 639);
            if ($urandom_range(0, 31) == 0) y = -longint'($urandom_range(1, 100000));
            send(x, y, $urandom);
        end
        tog_en = 1'b0;
        wr_ack = 1'b1;
        drain();
        chk("tog_left", exp_q.size(), 0);

        // clip saturation and frame_start coinciding with a clip
        pulse_fs();
        in_valid = 1'b1;
        ox_signed = -37'sd1;
        oy_signed = '0;
        repeat (65600) step();
        chk("clip_sat", clip_count, 16'hFFFF);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        in_valid = 1'b0;
        chk("clip_fs_evt", clip_count, 1);
        drain();

        // reset with queued entries
        wr_ack = 1'b0;
        pulse_fs();
        for (int k = 0; k < 5; k++) send(100 + k, 200, 12'h500 + k);
        in_valid = 1'b0;
        repeat (3) step();
        chk("prerst_wr_en", wr_en, 1);
        w0 = n_writes;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        wr_ack = 1'b1;
        repeat (20) step();
        chk("midrst_writes", n_writes - w0, 0);
        chk("final_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
